mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-stage access sequencer. Sits downstream of the EX_MEM buffer, between the pipeline
//  and a 16-bit-wide single-port synchronous data memory. Splits 32-bit accesses (PC/flags
//  push/pop, mem_type=1) into two 16-bit word cycles and stalls upstream stages while busy.
//  Flags out-of-range addresses as exceptions for EPC/CAUSE capture.
// PARAMETERS
//  ADDR_W     11    data-memory word-address width (dm_addr)
//  MEM_DEPTH  2048  number of 16-bit words; legal word addresses 0..MEM_DEPTH-1
//  EXC_CODE   4'd1  value driven on exc_cause for an out-of-range access
// PORTS
//  clk          in   1       clock; all state updates on posedge
//  reset        in   1       synchronous, active-low (reset==0 resets on the clock edge)
//  req_valid    in   1       EX_MEM holds a memory op this cycle
//  req_ready    out  1       unit can accept; upstream holds req_* and stalls while 0
//  mem_read     in   1       load/pop
//  mem_write    in   1       store/push
//  mem_type     in   1       0 = 16-bit access, 1 = 32-bit access (two words)
//  addr         in   32      word address from ALU/SP
//  wdata        in   32      store data; 16-bit uses [15:0]
//  resp_valid   out  1       one-cycle pulse: access complete (reads and writes)
//  resp_rdata   out  32      read data, valid when resp_valid && op was read
//  exc_valid    out  1       one-cycle pulse: access rejected
//  exc_cause    out  4       EXC_CODE when exc_valid, else 0
//  exc_addr     out  32      offending addr, held until next exception
//  dm_en        out  1       memory enable
//  dm_we        out  1       memory write enable
//  dm_addr      out  ADDR_W  memory word address
//  dm_wdata     out  16      memory write data
//  dm_rdata     in   16      memory read data, valid 1 cycle after dm_en && !dm_we
// BEHAVIOUR
//  Reset: state=IDLE; resp_valid, exc_valid, exc_cause, exc_addr, resp_rdata=0; dm_en/dm_we
//   forced 0 combinationally while reset==0. A reset mid-access abandons it (no resp, no exc).
//  FSM states IDLE, ACC0, ACC1, FIN. req_ready = (state==IDLE).
//  Accept: IDLE && req_valid && (mem_read|mem_write) on a rising edge; captures addr, wdata,
//   mem_type, and is_write = mem_write. Both read and write set -> treated as write.
//   req_valid with neither set -> ignored, stays IDLE.
//  Range check at accept: illegal if addr >= MEM_DEPTH, or mem_type && addr == MEM_DEPTH-1.
//   Illegal -> stay IDLE; next cycle exc_valid=1, exc_cause=EXC_CODE, exc_addr=addr; no dm_en.
//  ACC0: dm_en=1, dm_addr=addr, dm_we=is_write, dm_wdata=wdata[15:0]. -> ACC1 if mem_type else FIN.
//  ACC1: dm_en=1, dm_addr=addr+1, dm_we=is_write, dm_wdata=wdata[31:16]; read: latch
//   dm_rdata as low half. -> FIN.
//  FIN: dm_en=0. On leaving: resp_rdata <= mem_type ? {dm_rdata, low} : {16'h0, dm_rdata}
//   for reads (unchanged for writes); resp_valid <= 1 next cycle. -> IDLE.
//  Word order: addr holds bits [15:0], addr+1 holds [31:16].
//  Latency (accept edge to resp_valid high): 16-bit = 3 cycles, 32-bit = 4 cycles.
//   resp_valid coincides with req_ready=1, so a new request may be accepted that same cycle.
//  IDLE drives dm_en=0, dm_we=0; dm_addr/dm_wdata don't-care when dm_en=0.
//  exc_valid and resp_valid are never high together.
// TESTING
//  1. 16-bit write 0x1234 @0x20, then 16-bit read @0x20 -> one dm_we pulse; resp_rdata=0x00001234.
//  2. 32-bit write 0xDEADBEEF @0x10 -> dm writes BEEF@0x10 then DEAD@0x11 on consecutive
//     cycles; 32-bit read @0x10 -> resp_rdata=0xDEADBEEF, 4 cycles after accept.
//  3. 16-bit read @0x800 (MEM_DEPTH=2048) -> exc_valid=1, exc_cause=1, exc_addr=0x800,
//     no dm_en, no resp_valid; 32-bit @0x7FF -> same; 16-bit @0x7FF -> normal.
//  4. Back-to-back: hold req_valid through a 32-bit read -> req_ready low 3 cycles, second
//     request accepted on the resp_valid cycle; no request lost or duplicated.
//  5. reset=0 in ACC0 of a 32-bit write -> dm_we low that cycle, @addr+1 never written, IDLE after
//     the edge, all outputs 0.
//  6. mem_read & mem_write both high, 16-bit @0x5 -> performed as write; resp_rdata unchanged.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access sequencer: drives a 16-bit synchronous data memory and splits
// 32-bit accesses into two word cycles. It stalls upstream while busy and flags out-of-range addresses.
module mem_access_unit #(
  parameter int         ADDR_W    = 11,
  parameter int         MEM_DEPTH = 2048,
  parameter logic [3:0] EXC_CODE  = 4'd1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              mem_type,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              exc_valid,
  output logic [3:0]        exc_cause,
  output logic [31:0]       exc_addr,
  output logic              dm_en,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [15:0]       dm_wdata,
  input  logic [15:0]       dm_rdata
);

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              type_q;
  logic              write_q;
  logic [15:0]       low_q;
  logic              accept;
  logic              illegal;

  assign req_ready = (state == IDLE);
  assign accept    = (state == IDLE) && req_valid && (mem_read || mem_write);
  // A 32-bit access at the last word would spill its upper half past the end of memory.
  assign illegal   = (addr >= 32'(MEM_DEPTH)) || (mem_type && (addr == 32'(MEM_DEPTH - 1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      type_q     <= 1'b0;
      write_q    <= 1'b0;
      low_q      <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      exc_valid  <= 1'b0;
      exc_cause  <= '0;
      exc_addr   <= '0;
    end else begin
      resp_valid <= 1'b0;
      exc_valid  <= 1'b0;
      exc_cause  <= '0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (illegal) begin
              exc_valid <= 1'b1;
              exc_cause <= EXC_CODE;
              exc_addr  <= addr;
            end else begin
              addr_q  <= addr[ADDR_W-1:0];
              wdata_q <= wdata;
              type_q  <= mem_type;
              write_q <= mem_write;
              state   <= ACC0;
            end
          end
        end
        ACC0: state <= type_q ? ACC1 : FIN;
        ACC1: begin
          // Data for the ACC0 read arrives now; it is the low half of the result.
          if (!write_q) low_q <= dm_rdata;
          state <= FIN;
        end
        FIN: begin
          if (!write_q) resp_rdata <= type_q ? {dm_rdata, low_q} : {16'h0000, dm_rdata};
          resp_valid <= 1'b1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Memory strobes are gated by reset so an abandoned access never reaches the array.
  always_comb begin
    dm_en    = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = addr_q;
    dm_wdata = wdata_q[15:0];
    if (reset) begin
      case (state)
        ACC0: begin
          dm_en = 1'b1;
          dm_we = write_q;
        end
        ACC1: begin
          dm_en    = 1'b1;
          dm_we    = write_q;
          dm_addr  = addr_q + ADDR_W'(1);
          dm_wdata = wdata_q[31:16];
        end
        default: begin
          dm_en = 1'b0;
          dm_we = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: table of directed accesses against a
// behavioural 16-bit memory, plus back-to-back and mid-access reset sequences.
module tb_mem_access_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic        mem_type;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;
  logic        dm_en;
  logic        dm_we;
  logic [10:0] dm_addr;
  logic [15:0] dm_wdata;
  logic [15:0] dm_rdata;

  int checks = 0;
  int errors = 0;
  int en_cnt = 0;
  int we_cnt = 0;

  logic [15:0] mem [0:2047];

  mem_access_unit dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr),
    .dm_en(dm_en), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous memory with one-cycle read latency.
  always @(posedge clk) begin
    if (dm_en) begin
      en_cnt++;
      if (dm_we) begin
        mem[dm_addr] <= dm_wdata;
        we_cnt++;
      end else begin
        dm_rdata <= mem[dm_addr];
      end
    end
  end

  typedef struct {
    logic        rd;
    logic        wr;
    logic        typ;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_resp;
    logic        exp_exc;
    int          exp_lat;
    int          exp_en;
    int          exp_we;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v, output logic got_resp, output logic got_exc,
                                output int lat, output int en_d, output int we_d,
                                output logic [3:0] cause, output logic [31:0] eaddr);
    int en0;
    int we0;
    got_resp = 1'b0;
    got_exc  = 1'b0;
    lat      = 0;
    cause    = '0;
    eaddr    = '0;
    @(negedge clk);
    en0       = en_cnt;
    we0       = we_cnt;
    req_valid = 1'b1;
    mem_read  = v.rd;
    mem_write = v.wr;
    mem_type  = v.typ;
    addr      = v.addr;
    wdata     = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (resp_valid || exc_valid) begin
        got_resp = resp_valid;
        got_exc  = exc_valid;
        cause    = exc_cause;
        eaddr    = exc_addr;
        lat      = k + 1;
        break;
      end
      @(posedge clk); #1;
    end
    en_d = en_cnt - en0;
    we_d = we_cnt - we0;
  endtask

  vec_t        vecs [14];
  logic        got_resp;
  logic        got_exc;
  int          lat;
  int          en_d;
  int          we_d;
  logic [3:0]  cause;
  logic [31:0] eaddr;
  logic        ready_s [12];
  logic        resp_s [12];
  logic [31:0] rdata_s [12];
  int          n_low;
  int          n_resp;
  int          we0;

  initial begin
    //          rd    wr    typ   addr          wdata          resp  exc   lat en we rdata
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 32'h20,       32'h0000_1234, 1'b1, 1'b0, 3, 1, 1, 32'h0000_0000};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'h20,       32'h0,         1'b1, 1'b0, 3, 1, 0, 32'h0000_1234};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 32'h10,       32'hDEAD_BEEF, 1'b1, 1'b0, 4, 2, 2, 32'h0000_1234};
    vecs[3]  = '{1'b1, 1'b0, 1'b1, 32'h10,       32'h0,         1'b1, 1'b0, 4, 2, 0, 32'hDEAD_BEEF};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 32'h800,      32'h0,         1'b0, 1'b1, 1, 0, 0, 32'hDEAD_BEEF};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 32'h7FF,      32'h0,         1'b0, 1'b1, 1, 0, 0, 32'hDEAD_BEEF};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 32'h7FF,      32'hFFFF_A5A5, 1'b1, 1'b0, 3, 1, 1, 32'hDEAD_BEEF};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 32'h7FF,      32'h0,         1'b1, 1'b0, 3, 1, 0, 32'h0000_A5A5};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, 32'h5,        32'h0000_7777, 1'b1, 1'b0, 3, 1, 1, 32'h0000_A5A5};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h5,        32'h0,         1'b1, 1'b0, 3, 1, 0, 32'h0000_7777};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 32'h7FE,      32'h1234_5678, 1'b1, 1'b0, 4, 2, 2, 32'h0000_7777};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 32'h7FE,      32'h0,         1'b1, 1'b0, 4, 2, 0, 32'h1234_5678};
    vecs[12] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,        1'b0, 1'b1, 1, 0, 0, 32'h1234_5678};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 32'h20,       32'h0,         1'b0, 1'b0, 0, 0, 0, 32'h1234_5678};

    reset     = 1'b0;
    req_valid = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_type  = 1'b0;
    addr      = '0;
    wdata     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_ready", 32'(req_ready), 32'd1);
    check_output("reset_resp_valid", 32'(resp_valid), 32'd0);
    check_output("reset_exc_valid", 32'(exc_valid), 32'd0);
    check_output("reset_rdata", resp_rdata, 32'd0);
    check_output("reset_exc_addr", exc_addr, 32'd0);
    check_output("reset_dm_en", 32'(dm_en), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i], got_resp, got_exc, lat, en_d, we_d, cause, eaddr);
      check_output($sformatf("v%0d_resp", i), 32'(got_resp), 32'(vecs[i].exp_resp));
      check_output($sformatf("v%0d_exc", i), 32'(got_exc), 32'(vecs[i].exp_exc));
      check_output($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check_output($sformatf("v%0d_dm_en_cycles", i), 32'(en_d), 32'(vecs[i].exp_en));
      check_output($sformatf("v%0d_dm_writes", i), 32'(we_d), 32'(vecs[i].exp_we));
      check_output($sformatf("v%0d_rdata", i), resp_rdata, vecs[i].exp_rdata);
      if (vecs[i].exp_exc) begin
        check_output($sformatf("v%0d_exc_cause", i), 32'(cause), 32'd1);
        check_output($sformatf("v%0d_exc_addr", i), eaddr, vecs[i].addr);
      end
      @(posedge clk); #1;
      check_output($sformatf("v%0d_pulse_end", i), 32'({resp_valid, exc_valid}), 32'd0);
      if (i == 2) begin
        check_output("w32_low_word", 32'(mem[11'h10]), 32'h0000_BEEF);
        check_output("w32_high_word", 32'(mem[11'h11]), 32'h0000_DEAD);
      end
    end

    // Back-to-back: second request waits while the 32-bit read is busy.
    @(negedge clk);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    mem_type  = 1'b1;
    addr      = 32'h10;
    @(posedge clk); #1;
    mem_type = 1'b0;
    addr     = 32'h20;
    for (int k = 0; k < 12; k++) begin
      ready_s[k] = req_ready;
      resp_s[k]  = resp_valid;
      rdata_s[k] = resp_rdata;
      @(posedge clk); #1;
      if (k == 3) begin
        req_valid = 1'b0;
        mem_read  = 1'b0;
      end
    end
    n_low  = 0;
    n_resp = 0;
    for (int k = 0; k < 12; k++) begin
      if (k < 4 && !ready_s[k]) n_low++;
      if (resp_s[k]) n_resp++;
    end
    check_output("b2b_ready_low_cycles", 32'(n_low), 32'd3);
    check_output("b2b_resp_count", 32'(n_resp), 32'd2);
    check_output("b2b_first_resp", 32'({resp_s[3], ready_s[3]}), 32'd3);
    check_output("b2b_first_rdata", rdata_s[3], 32'hDEAD_BEEF);
    check_output("b2b_second_accepted", 32'(ready_s[4]), 32'd0);
    check_output("b2b_second_resp", 32'(resp_s[6]), 32'd1);
    check_output("b2b_second_rdata", rdata_s[6], 32'h0000_1234);

    // Reset during ACC0 of a 32-bit write abandons the access.
    @(negedge clk);
    we0       = we_cnt;
    req_valid = 1'b1;
    mem_write = 1'b1;
    mem_type  = 1'b1;
    addr      = 32'h30;
    wdata     = 32'hCAFE_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_write = 1'b0;
    check_output("rst_acc0_dm_we_before", 32'(dm_we), 32'd1);
    reset = 1'b0;
    #1;
    check_output("rst_acc0_dm_we", 32'(dm_we), 32'd0);
    check_output("rst_acc0_dm_en", 32'(dm_en), 32'd0);
    @(posedge clk); #1;
    check_output("rst_idle_ready", 32'(req_ready), 32'd1);
    check_output("rst_outputs", 32'({resp_valid, exc_valid, exc_cause}), 32'd0);
    check_output("rst_rdata", resp_rdata, 32'd0);
    check_output("rst_exc_addr", exc_addr, 32'd0);
    reset = 1'b1;
    n_resp = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (resp_valid || exc_valid || !req_ready) n_resp++;
    end
    check_output("rst_no_activity", 32'(n_resp), 32'd0);
    check_output("rst_no_writes", 32'(we_cnt - we0), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
